// File: rtl/pc_sequencer.sv
// Program-counter sequencer: walks fetch -> decode -> execute against a
// single-beat instruction memory, with branch loading and halt/resume control.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | after reset; waits for start (halt_req takes priority)
// FETCH   | mem_req high at mem_addr=pc; waits indefinitely for mem_ack
// DECODE  | single cycle, ir_valid high, ir holds the fetched byte
// EXECUTE | waits for exec_done; optional branch load, then FETCH or HALT
// HALT    | halted high; start resumes fetching from the retained pc
module pc_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       exec_done,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       halt_req,
    output logic [7:0] pc,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic [7:0] ir,
    output logic       ir_valid,
    output logic       halted,
    output logic       wrapped
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t     state;
    logic [8:0] pc_inc;

    // Ninth bit is the carry out of the fetch increment; only it may set wrapped.
    assign pc_inc = {1'b0, pc} + 9'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ir      <= 8'h00;
            wrapped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt_req)
                        state <= HALT;
                    else if (start)
                        state <= FETCH;
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc_inc[7:0];
                        state <= DECODE;
                        if (pc_inc[8])
                            wrapped <= 1'b1;
                    end
                end
                DECODE: begin
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    if (exec_done) begin
                        if (branch_taken)
                            pc <= branch_target;
                        state <= halt_req ? HALT : FETCH;
                    end
                end
                HALT: begin
                    if (start)
                        state <= FETCH;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req  = (state == FETCH);
    assign ir_valid = (state == DECODE);
    assign halted   = (state == HALT);
    assign mem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (RESET_PC 00 and FF) share stimulus;
// fetched {ir,pc} expectations are queued at the ack and popped at DECODE.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset, start, mem_ack, exec_done, branch_taken, halt_req;
    logic [7:0] mem_rdata, branch_target;

    logic [7:0] a_pc, a_mem_addr, a_ir;
    logic       a_mem_req, a_ir_valid, a_halted, a_wrapped;
    logic [7:0] b_pc, b_mem_addr, b_ir;
    logic       b_mem_req, b_ir_valid, b_halted, b_wrapped;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_pc_a, m_pc_b;
    logic        m_wrap_a, m_wrap_b;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    always #5 clock = ~clock;

    pc_sequencer #(.RESET_PC(8'h00)) dut_a (
        .clock(clock), .reset(reset), .start(start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .pc(a_pc),
        .mem_req(a_mem_req), .mem_addr(a_mem_addr), .ir(a_ir),
        .ir_valid(a_ir_valid), .halted(a_halted), .wrapped(a_wrapped)
    );

    pc_sequencer #(.RESET_PC(8'hFF)) dut_b (
        .clock(clock), .reset(reset), .start(start), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .exec_done(exec_done), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt_req(halt_req), .pc(b_pc),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .ir(b_ir),
        .ir_valid(b_ir_valid), .halted(b_halted), .wrapped(b_wrapped)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; mem_ack = 0; mem_rdata = 8'h00; exec_done = 0;
        branch_taken = 0; branch_target = 8'h00; halt_req = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        m_pc_a = 8'h00; m_pc_b = 8'hFF; m_wrap_a = 0; m_wrap_b = 0;
        checks++;
        if (a_mem_req !== 1'b0 || a_ir_valid !== 1'b0 || a_halted !== 1'b0 ||
            a_mem_addr !== 8'h00 || a_ir !== 8'h00 || a_wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_a req=%b irv=%b halt=%b addr=%h ir=%h wrap=%b expected 0 0 0 00 00 0",
                     a_mem_req, a_ir_valid, a_halted, a_mem_addr, a_ir, a_wrapped);
        end
        checks++;
        if (b_pc !== 8'hFF || b_mem_addr !== 8'hFF || b_mem_req !== 1'b0 || b_wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_b pc=%h addr=%h req=%b wrap=%b expected FF FF 0 0",
                     b_pc, b_mem_addr, b_mem_req, b_wrapped);
        end
    endtask

    task automatic go_start();
        start = 1;
        step();
        start = 0;
        checks++;
        if (a_mem_req !== 1'b1 || a_halted !== 1'b0 || a_mem_addr !== m_pc_a || b_mem_addr !== m_pc_b) begin
            failures++;
            $display("FAIL start_fetch req=%b halt=%b addr_a=%h addr_b=%h expected 1 0 %h %h",
                     a_mem_req, a_halted, a_mem_addr, b_mem_addr, m_pc_a, m_pc_b);
        end
    endtask

    // In FETCH: stall, then ack with data; expects DECODE then EXECUTE.
    task automatic do_fetch(input int stall, input logic [7:0] data);
        int         req_cycles;
        logic [8:0] nxt;
        logic [15:0] exp_a, exp_b;
        req_cycles = 0;
        for (int i = 0; i < stall; i++) begin
            // sampled-elsewhere inputs must be ignored during a stall
            exec_done = 1; branch_taken = 1; branch_target = 8'h99; halt_req = 1;
            checks++;
            if (a_mem_req !== 1'b1 || a_mem_addr !== m_pc_a || a_ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL fetch_stall cyc=%0d req=%b addr=%h irv=%b expected 1 %h 0",
                         i, a_mem_req, a_mem_addr, a_ir_valid, m_pc_a);
            end
            if (a_mem_req === 1'b1) req_cycles++;
            step();
        end
        exec_done = 0; branch_taken = 0; branch_target = 8'h00; halt_req = 0;
        if (a_mem_req === 1'b1) req_cycles++;
        mem_ack = 1;
        mem_rdata = data;
        nxt = {1'b0, m_pc_a} + 9'd1;
        m_pc_a = nxt[7:0];
        if (nxt[8]) m_wrap_a = 1;
        nxt = {1'b0, m_pc_b} + 9'd1;
        m_pc_b = nxt[7:0];
        if (nxt[8]) m_wrap_b = 1;
        q_a.push_back({data, m_pc_a});
        q_b.push_back({data, m_pc_b});
        step();
        mem_ack = 0;
        mem_rdata = 8'h00;
        checks++;
        if (req_cycles != stall + 1) begin
            failures++;
            $display("FAIL fetch_req_len got=%0d expected=%0d", req_cycles, stall + 1);
        end
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        checks++;
        if (a_ir_valid !== 1'b1 || a_mem_req !== 1'b0 || {a_ir, a_pc} !== exp_a || a_wrapped !== m_wrap_a) begin
            failures++;
            $display("FAIL decode_a irv=%b req=%b ir_pc=%h wrap=%b expected 1 0 %h %b",
                     a_ir_valid, a_mem_req, {a_ir, a_pc}, a_wrapped, exp_a, m_wrap_a);
        end
        checks++;
        if (b_ir_valid !== 1'b1 || {b_ir, b_pc} !== exp_b || b_wrapped !== m_wrap_b) begin
            failures++;
            $display("FAIL decode_b irv=%b ir_pc=%h wrap=%b expected 1 %h %b",
                     b_ir_valid, {b_ir, b_pc}, b_wrapped, exp_b, m_wrap_b);
        end
        step();
        checks++;
        if (a_ir_valid !== 1'b0 || a_mem_req !== 1'b0 || a_halted !== 1'b0) begin
            failures++;
            $display("FAIL execute_entry irv=%b req=%b halt=%b expected 0 0 0",
                     a_ir_valid, a_mem_req, a_halted);
        end
    endtask

    // In EXECUTE: wait delay cycles (mem_ack noise), then exec_done.
    task automatic do_exec(input int delay, input logic br, input logic [7:0] tgt, input logic hlt);
        for (int i = 0; i < delay; i++) begin
            mem_ack = 1; mem_rdata = 8'h5A;
            step();
            checks++;
            if (a_mem_req !== 1'b0 || a_pc !== m_pc_a || a_ir_valid !== 1'b0) begin
                failures++;
                $display("FAIL execute_wait req=%b pc=%h irv=%b expected 0 %h 0",
                         a_mem_req, a_pc, a_ir_valid, m_pc_a);
            end
        end
        mem_ack = 0; mem_rdata = 8'h00;
        exec_done = 1; branch_taken = br; branch_target = tgt; halt_req = hlt;
        if (br) begin
            m_pc_a = tgt;
            m_pc_b = tgt;
        end
        step();
        clear_inputs();
        checks++;
        if (a_halted !== hlt || a_mem_req !== !hlt || a_pc !== m_pc_a || a_mem_addr !== m_pc_a) begin
            failures++;
            $display("FAIL exec_done_a halt=%b req=%b pc=%h addr=%h expected %b %b %h %h",
                     a_halted, a_mem_req, a_pc, a_mem_addr, hlt, !hlt, m_pc_a, m_pc_a);
        end
        checks++;
        if (b_pc !== m_pc_b || a_wrapped !== m_wrap_a || b_wrapped !== m_wrap_b) begin
            failures++;
            $display("FAIL exec_done_b pc=%h wrap_a=%b wrap_b=%b expected %h %b %b",
                     b_pc, a_wrapped, b_wrapped, m_pc_b, m_wrap_a, m_wrap_b);
        end
    endtask

    task automatic test_normal_flow();
        go_start();
        do_fetch(0, 8'hA5);
        do_exec(0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_mem_stall();
        do_fetch(5, 8'h3C);
        do_exec(2, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_branch();
        do_fetch(0, 8'h11);
        do_exec(0, 1'b1, 8'h40, 1'b0);
        do_fetch(1, 8'h22);
        do_exec(0, 1'b0, 8'hEE, 1'b0);
    endtask

    task automatic test_halt_resume();
        do_fetch(0, 8'h33);
        do_exec(1, 1'b1, 8'h10, 1'b1);
        halt_req = 1;
        step();
        halt_req = 0;
        checks++;
        if (a_halted !== 1'b1 || a_mem_req !== 1'b0 || a_pc !== 8'h10) begin
            failures++;
            $display("FAIL halt_hold halt=%b req=%b pc=%h expected 1 0 10", a_halted, a_mem_req, a_pc);
        end
        go_start();
    endtask

    task automatic test_wrap_branch();
        do_fetch(0, 8'h44);
        do_exec(0, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        mem_ack = 1; mem_rdata = 8'h77; start = 1; reset = 1;
        step();
        checks++;
        if (a_mem_req !== 1'b0 || a_ir !== 8'h00 || a_pc !== 8'h00 || b_pc !== 8'hFF || b_wrapped !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fetch req=%b ir=%h pc_a=%h pc_b=%h wrap_b=%b expected 0 00 00 FF 0",
                     a_mem_req, a_ir, a_pc, b_pc, b_wrapped);
        end
        step();
        clear_inputs();
        reset = 0;
        m_pc_a = 8'h00; m_pc_b = 8'hFF; m_wrap_a = 0; m_wrap_b = 0;
        checks++;
        if (a_mem_req !== 1'b0 || a_halted !== 1'b0 || a_ir_valid !== 1'b0 || b_ir !== 8'h00) begin
            failures++;
            $display("FAIL reset_held req=%b halt=%b irv=%b ir_b=%h expected 0 0 0 00",
                     a_mem_req, a_halted, a_ir_valid, b_ir);
        end
        step();
        checks++;
        if (a_mem_req !== 1'b0 || a_halted !== 1'b0) begin
            failures++;
            $display("FAIL idle_stay req=%b halt=%b expected 0 0", a_mem_req, a_halted);
        end
    endtask

    task automatic test_idle_halt();
        halt_req = 1; start = 1;
        step();
        clear_inputs();
        checks++;
        if (a_halted !== 1'b1 || a_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL idle_halt_priority halt=%b req=%b expected 1 0", a_halted, a_mem_req);
        end
        go_start();
        do_fetch(0, 8'h66);
        do_exec(0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_normal_flow();
        test_mem_stall();
        test_branch();
        test_halt_resume();
        test_wrap_branch();
        test_reset_mid_fetch();
        test_idle_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 8'h00, giving the PC value loaded on reset.
REQ-002 The block SHALL have the port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit: leave IDLE or HALT and begin fetching.
REQ-005 The block SHALL have the port mem_ack, input, 1 bit: instruction memory returns valid mem_rdata this cycle.
REQ-006 The block SHALL have the port mem_rdata, input, 8 bits: fetched instruction byte.
REQ-007 The block SHALL have the port exec_done, input, 1 bit: datapath has finished the current instruction.
REQ-008 The block SHALL have the port branch_taken, input, 1 bit: load branch_target; sampled only with exec_done.
REQ-009 The block SHALL have the port branch_target, input, 8 bits: next PC when a branch is taken.
REQ-010 The block SHALL have the port halt_req, input, 1 bit: stop at the instruction boundary; sampled in IDLE or with exec_done.
REQ-011 The block SHALL have the port pc, output, 8 bits: current program counter.
REQ-012 The block SHALL have the port mem_req, output, 1 bit: fetch request; high only in FETCH.
REQ-013 The block SHALL have the port mem_addr, output, 8 bits: fetch address, equal to pc.
REQ-014 The block SHALL have the port ir, output, 8 bits: instruction register.
REQ-015 The block SHALL have the port ir_valid, output, 1 bit: one-cycle pulse in DECODE.
REQ-016 The block SHALL have the port halted, output, 1 bit: high while in HALT.
REQ-017 The block SHALL have the port wrapped, output, 1 bit: sticky flag, set when an increment wraps pc from 8'hFF to 8'h00.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, FETCH, DECODE, EXECUTE and HALT; mem_req, ir_valid and halted SHALL be decoded from the state only.
REQ-019 In IDLE, halt_req=1 SHALL go to HALT; otherwise start=1 SHALL go to FETCH; otherwise the FSM SHALL stay in IDLE.
REQ-020 In FETCH, mem_req=1 and mem_addr=pc; with mem_ack=0 the FSM SHALL hold FETCH with pc and ir unchanged, with no timeout.
REQ-021 In FETCH with mem_ack=1, the edge SHALL load ir<=mem_rdata and pc<=pc+1 (8-bit modulo, carry discarded), and the FSM SHALL go to DECODE.
REQ-022 A FETCH increment from 8'hFF SHALL yield 8'h00 and set wrapped=1; wrapped SHALL clear only on reset.
REQ-023 DECODE SHALL last exactly one cycle with ir_valid=1, then go to EXECUTE.
REQ-024 EXECUTE SHALL hold until exec_done=1; on that edge pc<=branch_target if branch_taken=1, else pc is unchanged.
REQ-025 In EXECUTE with exec_done=1, halt_req=1 SHALL go to HALT; otherwise the FSM SHALL go to FETCH.
REQ-026 When branch_taken and halt_req coincide, the branch SHALL load pc before the FSM enters HALT.
REQ-027 A branch load SHALL never set wrapped, including a branch to 8'h00.
REQ-028 In HALT, start=1 SHALL go to FETCH with pc retained; halt_req has no effect while in HALT.
REQ-029 mem_ack outside FETCH, and exec_done, branch_taken and halt_req outside their sampling states, SHALL be ignored.
REQ-030 Minimum instruction latency SHALL be 3 cycles (FETCH with same-cycle ack, DECODE, EXECUTE with same-cycle exec_done); mem_req SHALL re-assert on the cycle after exec_done.

Reset
REQ-031 A clock edge with reset=1 SHALL force IDLE, pc=RESET_PC, ir=8'h00 and wrapped=0, overriding all other inputs.
REQ-032 From the reset edge, the outputs SHALL be mem_req=0, ir_valid=0, halted=0 and mem_addr=RESET_PC.
REQ-033 Reset in any state, including mid-FETCH with mem_ack=1, SHALL discard the pending transfer, with no pc or ir update.
REQ-034 Reset held for multiple cycles SHALL keep the block in IDLE.

Verification
REQ-035 The bench SHALL cover normal flow: reset, start, mem_ack same cycle with rdata=8'hA5, exec_done next EXECUTE cycle -> ir=8'hA5, pc=8'h01, ir_valid for 1 cycle, mem_req again at cycle 4.
REQ-036 The bench SHALL cover memory stall: mem_ack delayed 5 cycles -> mem_req held 6 cycles, mem_addr stable, pc increments once.
REQ-037 The bench SHALL cover a branch: in EXECUTE, exec_done=1, branch_taken=1, target=8'h40 -> next FETCH mem_addr=8'h40; exec_done=1 with branch_taken=0 -> pc unchanged.
REQ-038 The bench SHALL cover wrap: RESET_PC=8'hFF, one fetch -> pc=8'h00 and wrapped=1; a later branch to 8'h00 leaves wrapped unchanged.
REQ-039 The bench SHALL cover halt and resume: exec_done with halt_req=1 and branch_taken=1 to 8'h10 -> halted=1, pc=8'h10; start -> FETCH at 8'h10.
REQ-040 The bench SHALL cover reset mid-fetch: reset=1 with mem_ack=1 -> next cycle IDLE, pc=RESET_PC, ir=8'h00, mem_req=0.
